// File: rtl/clock_core_multi_alarm_if.sv
// Button pulses in, display / status out, shared by the clock core and its user.
// master = button and display side, slave = the clock core itself.
interface clock_core_multi_alarm_if #(
   parameter int NUM_ALARMS = 2
);
   logic                  up_pulse;
   logic                  down_pulse;
   logic                  mode_pulse;
   logic                  adjust_pulse;
   logic [23:0]           disp_bcd;
   logic [5:0]            blink_mask;
   logic [2:0]            state;
   logic [3:0]            view_sel;
   logic [NUM_ALARMS-1:0] alarm_en;
   logic                  ring;
   logic [2:0]            ring_src;
   logic                  sec_tick;

   modport master (
      output up_pulse, down_pulse, mode_pulse, adjust_pulse,
      input  disp_bcd, blink_mask, state, view_sel, alarm_en, ring, ring_src, sec_tick
   );

   modport slave (
      input  up_pulse, down_pulse, mode_pulse, adjust_pulse,
      output disp_bcd, blink_mask, state, view_sel, alarm_en, ring, ring_src, sec_tick
   );
endinterface

// File: rtl/clock_core_multi_alarm.sv
// BCD time-of-day clock with mode/edit FSM and NUM_ALARMS HH:MM alarms,
// driving a 6-digit display word and blink mask.
module clock_core_multi_alarm #(
   parameter int CLK_FREQ   = 50000000,
   parameter int NUM_ALARMS = 2,
   parameter int RING_SECS  = 30
) (
   input  logic clk,
   input  logic rst,
   clock_core_multi_alarm_if.slave bus
);
   localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

   typedef enum logic [2:0] {
      RUN = 3'd0, SET_H = 3'd1, SET_M = 3'd2, SET_S = 3'd3,
      VIEW_ALM = 3'd4, ALM_H = 3'd5, ALM_M = 3'd6
   } state_t;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
      if (v == top) return 8'h00;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return v + 8'd1;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
      if (v == 8'h00) return top;
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      return v - 8'd1;
   endfunction

   function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] top,
                                           input logic up);
      return up ? bcd_inc(v, top) : bcd_dec(v, top);
   endfunction

   state_t                state_q;
   logic [PW-1:0]         presc_q;
   logic [7:0]            hh_q, mm_q, ss_q;
   logic [7:0]            alm_h_q [NUM_ALARMS];
   logic [7:0]            alm_m_q [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] alarm_en_q;
   logic [3:0]            view_q;
   logic                  ring_q;
   logic [2:0]            ring_src_q;
   logic [7:0]            ring_cnt_q;

   logic       in_set, alm_view, tick, carry_s, carry_m;
   logic [7:0] ss_t, mm_t, hh_t;

   assign in_set   = state_q inside {SET_H, SET_M, SET_S};
   assign alm_view = state_q inside {VIEW_ALM, ALM_H, ALM_M};
   // The prescaler is parked in SET_S, so no second can elapse there.
   assign tick     = (presc_q == PW'(CLK_FREQ - 1)) && (state_q != SET_S);
   assign carry_s  = (ss_q == 8'h59);
   assign carry_m  = carry_s && (mm_q == 8'h59);
   assign ss_t     = bcd_inc(ss_q, 8'h59);
   assign mm_t     = carry_s ? bcd_inc(mm_q, 8'h59) : mm_q;
   assign hh_t     = carry_m ? bcd_inc(hh_q, 8'h23) : hh_q;

   // While ringing every button only acknowledges; none reaches the FSM.
   logic any_btn, up_e, dn_e, mode_e, adj_e;
   assign any_btn = bus.up_pulse | bus.down_pulse | bus.mode_pulse | bus.adjust_pulse;
   assign up_e    = bus.up_pulse & ~bus.down_pulse & ~ring_q;
   assign dn_e    = bus.down_pulse & ~bus.up_pulse & ~ring_q;
   assign mode_e  = bus.mode_pulse & ~ring_q;
   assign adj_e   = bus.adjust_pulse & ~ring_q;

   logic [NUM_ALARMS-1:0] hit;
   logic                  match;
   logic [2:0]            match_idx;
   logic [IW-1:0]         sel;

   generate
      for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_match
         assign hit[gi] = alarm_en_q[gi] && (alm_h_q[gi] == hh_t) && (alm_m_q[gi] == mm_t);
      end
   endgenerate

   assign match = tick && carry_s && !in_set && (|hit);

   always_comb begin
      match_idx = 3'd0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (hit[i]) match_idx = 3'(i);
      end
   end

   assign sel = IW'(view_q - 4'd1);

   assign bus.disp_bcd = alm_view ? {alm_h_q[sel], alm_m_q[sel], 8'h00} : {hh_q, mm_q, ss_q};
   assign bus.state    = state_q;
   assign bus.view_sel = view_q;
   assign bus.alarm_en = alarm_en_q;
   assign bus.ring     = ring_q;
   assign bus.ring_src = ring_src_q;
   assign bus.sec_tick = tick;

   always_comb begin
      case (state_q)
         SET_H, ALM_H: bus.blink_mask = 6'b110000;
         SET_M, ALM_M: bus.blink_mask = 6'b001100;
         SET_S:        bus.blink_mask = 6'b000011;
         default:      bus.blink_mask = 6'b000000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         presc_q    <= '0;
         hh_q       <= 8'h00;
         mm_q       <= 8'h00;
         ss_q       <= 8'h00;
         alarm_en_q <= '0;
         view_q     <= 4'd0;
         ring_q     <= 1'b0;
         ring_src_q <= 3'd0;
         ring_cnt_q <= 8'd0;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            alm_h_q[i] <= 8'h00;
            alm_m_q[i] <= 8'h00;
         end
      end else begin
         if (state_q == SET_S || tick) presc_q <= '0;
         else                         presc_q <= presc_q + 1'b1;

         if (tick) begin
            ss_q <= ss_t;
            mm_q <= mm_t;
            hh_q <= hh_t;
         end

         if (match) begin
            ring_q     <= 1'b1;
            ring_src_q <= match_idx;
            ring_cnt_q <= 8'(RING_SECS);
         end else if (ring_q && any_btn) begin
            ring_q <= 1'b0;
         end else if (ring_q && tick) begin
            ring_cnt_q <= ring_cnt_q - 8'd1;
            if (ring_cnt_q == 8'd1) ring_q <= 1'b0;
         end

         // Edits are placed after the tick update so they override a carry into the same field.
         case (state_q)
            RUN: begin
               if (mode_e) begin
                  state_q <= VIEW_ALM;
                  view_q  <= 4'd1;
               end else if (adj_e) begin
                  state_q <= SET_H;
               end
            end
            SET_H: begin
               if (adj_e) state_q <= SET_M;
               if (up_e || dn_e) hh_q <= bcd_step(hh_q, 8'h23, up_e);
            end
            SET_M: begin
               if (adj_e) state_q <= SET_S;
               if (up_e || dn_e) mm_q <= bcd_step(mm_q, 8'h59, up_e);
            end
            SET_S: begin
               if (adj_e) state_q <= RUN;
               if (up_e || dn_e) ss_q <= bcd_step(ss_q, 8'h59, up_e);
            end
            VIEW_ALM: begin
               if (mode_e) begin
                  if (view_q == 4'(NUM_ALARMS)) begin
                     state_q <= RUN;
                     view_q  <= 4'd0;
                  end else begin
                     view_q <= view_q + 4'd1;
                  end
               end else if (adj_e) begin
                  state_q <= ALM_H;
               end else if (up_e) begin
                  alarm_en_q[sel] <= ~alarm_en_q[sel];
               end
            end
            ALM_H: begin
               if (adj_e) state_q <= ALM_M;
               if (up_e || dn_e) alm_h_q[sel] <= bcd_step(alm_h_q[sel], 8'h23, up_e);
            end
            ALM_M: begin
               if (adj_e) state_q <= VIEW_ALM;
               if (up_e || dn_e) alm_m_q[sel] <= bcd_step(alm_m_q[sel], 8'h59, up_e);
            end
            default: state_q <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_clock_core_multi_alarm.sv
// Directed bench for clock_core_multi_alarm with CLK_FREQ=10, two alarms, 3 s ring.
module tb_clock_core_multi_alarm;
   localparam int B_UP = 0, B_DN = 1, B_MODE = 2, B_ADJ = 3, B_BOTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   clock_core_multi_alarm_if #(.NUM_ALARMS(2)) bus_if ();

   clock_core_multi_alarm #(
      .CLK_FREQ(10), .NUM_ALARMS(2), .RING_SECS(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("  ok   %-16s = %h", tag, got);
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int b);
      bus_if.up_pulse     = (b == B_UP || b == B_BOTH);
      bus_if.down_pulse   = (b == B_DN || b == B_BOTH);
      bus_if.mode_pulse   = (b == B_MODE);
      bus_if.adjust_pulse = (b == B_ADJ);
      step();
      bus_if.up_pulse     = 1'b0;
      bus_if.down_pulse   = 1'b0;
      bus_if.mode_pulse   = 1'b0;
      bus_if.adjust_pulse = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // From RUN: walk the edit states, trim minutes and seconds down to 00:00:58, back to RUN.
   task automatic go_58(input int min_downs, input int sec_downs);
      press(B_ADJ);
      press(B_ADJ);
      repeat (min_downs) press(B_DN);
      press(B_ADJ);
      repeat (sec_downs) press(B_DN);
      check_eq("preset_58", {8'h0, bus_if.disp_bcd}, 32'h000058);
      press(B_ADJ);
   endtask

   task automatic wait_ring(input string tag);
      int lat = -1;
      for (int i = 1; i <= 60; i++) begin
         step();
         if (bus_if.ring) begin
            lat = i;
            break;
         end
      end
      check_eq(tag, lat, 20);
      check_eq("ring_src", {29'h0, bus_if.ring_src}, 32'd0);
      check_eq("ring_time", {8'h0, bus_if.disp_bcd}, 32'h000100);
   endtask

   initial begin
      int ticks, first, lat;
      bus_if.up_pulse     = 1'b0;
      bus_if.down_pulse   = 1'b0;
      bus_if.mode_pulse   = 1'b0;
      bus_if.adjust_pulse = 1'b0;

      // Reset values and free-running seconds
      do_reset();
      check_eq("rst_disp", {8'h0, bus_if.disp_bcd}, 32'h0);
      check_eq("rst_state", {29'h0, bus_if.state}, 32'd0);
      check_eq("rst_ring", {31'h0, bus_if.ring}, 32'd0);
      check_eq("rst_ring_src", {29'h0, bus_if.ring_src}, 32'd0);
      check_eq("rst_tick", {31'h0, bus_if.sec_tick}, 32'd0);
      check_eq("rst_blink", {26'h0, bus_if.blink_mask}, 32'd0);
      check_eq("rst_view", {28'h0, bus_if.view_sel}, 32'd0);
      check_eq("rst_alarm_en", {30'h0, bus_if.alarm_en}, 32'd0);
      ticks = 0;
      first = -1;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (bus_if.sec_tick) begin
            ticks++;
            if (first < 0) first = i;
         end
      end
      check_eq("first_tick", first, 9);
      check_eq("tick_count", ticks, 10);
      check_eq("s_after_10", {8'h0, bus_if.disp_bcd}, 32'h000010);

      // Hour edit and wrap in both directions
      do_reset();
      press(B_ADJ);
      check_eq("seth_state", {29'h0, bus_if.state}, 32'd1);
      check_eq("seth_blink", {26'h0, bus_if.blink_mask}, 32'b110000);
      press(B_DN);
      check_eq("h_dec_wrap", {24'h0, bus_if.disp_bcd[23:16]}, 32'h23);
      repeat (25) press(B_UP);
      check_eq("h_25_up", {24'h0, bus_if.disp_bcd[23:16]}, 32'h00);
      press(B_BOTH);
      check_eq("h_up_dn", {24'h0, bus_if.disp_bcd[23:16]}, 32'h00);
      press(B_MODE);
      check_eq("mode_ignored", {29'h0, bus_if.state}, 32'd1);

      // Preset 23:59:59, let it roll over
      do_reset();
      press(B_ADJ);
      press(B_DN);
      press(B_ADJ);
      check_eq("setm_blink", {26'h0, bus_if.blink_mask}, 32'b001100);
      press(B_DN);
      press(B_ADJ);
      check_eq("sets_state", {29'h0, bus_if.state}, 32'd3);
      check_eq("sets_blink", {26'h0, bus_if.blink_mask}, 32'b000011);
      press(B_DN);
      check_eq("preset_235959", {8'h0, bus_if.disp_bcd}, 32'h235959);
      press(B_ADJ);
      repeat (9) step();
      check_eq("wrap_tick", {31'h0, bus_if.sec_tick}, 32'd1);
      check_eq("wrap_before", {8'h0, bus_if.disp_bcd}, 32'h235959);
      step();
      check_eq("wrap_after", {8'h0, bus_if.disp_bcd}, 32'h000000);

      // Seconds freeze in SET_S, full second after leaving
      press(B_ADJ);
      press(B_ADJ);
      press(B_ADJ);
      repeat (7) press(B_UP);
      ticks = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bus_if.sec_tick) ticks++;
      end
      check_eq("freeze_ticks", ticks, 0);
      check_eq("freeze_s", {8'h0, bus_if.disp_bcd}, 32'h000007);
      press(B_ADJ);
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (bus_if.disp_bcd[7:0] != 8'h07) begin
            lat = i;
            break;
         end
      end
      check_eq("exit_latency", lat, 10);
      check_eq("exit_s", {8'h0, bus_if.disp_bcd}, 32'h000008);

      // Program both alarms to 00:01 and enable them
      do_reset();
      press(B_MODE);
      check_eq("view1_state", {29'h0, bus_if.state}, 32'd4);
      check_eq("view1_sel", {28'h0, bus_if.view_sel}, 32'd1);
      press(B_ADJ);
      check_eq("almh_state", {29'h0, bus_if.state}, 32'd5);
      press(B_ADJ);
      check_eq("almm_blink", {26'h0, bus_if.blink_mask}, 32'b001100);
      press(B_UP);
      check_eq("alm0_disp", {8'h0, bus_if.disp_bcd}, 32'h000100);
      press(B_ADJ);
      press(B_UP);
      check_eq("alm0_en", {30'h0, bus_if.alarm_en}, 32'b01);
      press(B_MODE);
      check_eq("view2_sel", {28'h0, bus_if.view_sel}, 32'd2);
      press(B_ADJ);
      press(B_ADJ);
      press(B_UP);
      press(B_ADJ);
      press(B_UP);
      check_eq("alm1_disp_s0", {8'h0, bus_if.disp_bcd}, 32'h000100);
      check_eq("alm_en_both", {30'h0, bus_if.alarm_en}, 32'b11);
      press(B_MODE);
      check_eq("back_run", {29'h0, bus_if.state}, 32'd0);
      check_eq("back_view", {28'h0, bus_if.view_sel}, 32'd0);
      check_eq("run_disp", {8'h0, bus_if.disp_bcd}, 32'h000001);

      // Match, then acknowledge with up_pulse
      go_58(0, 3);
      wait_ring("ring1_latency");
      press(B_UP);
      check_eq("ack_ring", {31'h0, bus_if.ring}, 32'd0);
      check_eq("ack_state", {29'h0, bus_if.state}, 32'd0);
      check_eq("ack_alarm_en", {30'h0, bus_if.alarm_en}, 32'b11);

      // Ring runs out after RING_SECS ticks
      go_58(1, 2);
      wait_ring("ring2_latency");
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         step();
         if (!bus_if.ring) begin
            lat = i;
            break;
         end
      end
      check_eq("ring_timeout", lat, 30);

      // Asynchronous reset while ringing
      go_58(1, 5);
      wait_ring("ring3_latency");
      rst = 1'b1;
      #1;
      check_eq("arst_ring", {31'h0, bus_if.ring}, 32'd0);
      check_eq("arst_alarm_en", {30'h0, bus_if.alarm_en}, 32'd0);
      check_eq("arst_disp", {8'h0, bus_if.disp_bcd}, 32'h0);
      check_eq("arst_state", {29'h0, bus_if.state}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/clock_core_multi_alarm.md
Name: clock_core_multi_alarm

Overview:
- Parametrised successor of the digital clock top-level.
- Merges timekeeping, mode/adjust FSM and a bank of NUM_ALARMS alarms into one synchronous block on the system clock.
- Presents a 6-digit BCD display word plus per-digit blink mask to the downstream scan driver.
- Buttons arrive as pre-debounced single-cycle pulses synchronous to clk.

Parameters:
- CLK_FREQ, 50000000, clk cycles per second; the prescaler divides by this.
- NUM_ALARMS, 2, number of independent HH:MM alarms, range 1..8.
- RING_SECS, 30, ring duration in seconds before auto-stop, range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- up_pulse  in  1  increment / toggle request, one cycle wide.
- down_pulse  in  1  decrement request, one cycle wide.
- mode_pulse  in  1  view-cycling request, one cycle wide.
- adjust_pulse  in  1  enter/advance edit, one cycle wide.
- disp_bcd  out  24  digits [23:20]..[3:0] = H1 H0 M1 M0 S1 S0 of the currently viewed item.
- blink_mask  out  6  bit i=1 means disp_bcd digit i blinks; bit 5 = H1.
- state  out  3  FSM state encoding, listed below.
- view_sel  out  4  0 = time, k+1 = alarm k.
- alarm_en  out  NUM_ALARMS  per-alarm enable.
- ring  out  1  alarm sounding.
- ring_src  out  3  index of the alarm that started the current ring.
- sec_tick  out  1  one-cycle pulse per elapsed second.

Behaviour:
- Reset (async assert, sync release):
  - Time is 00:00:00, all alarms 00:00 and disabled.
  - state=RUN, view_sel=0, ring=0, ring_src=0, sec_tick=0, blink_mask=0, prescaler=0.
- Prescaler:
  - Counts 0..CLK_FREQ-1. sec_tick=1 in the cycle the count equals CLK_FREQ-1, then the count wraps to 0.
  - Time increments on that same cycle and is visible the next cycle.
- Time arithmetic is BCD:
  - Seconds carry into minutes; minutes carry into hours.
  - Hours wrap 23 to 00.
  - 23:59:59 plus a tick gives 00:00:00.
- FSM states:
  - 0 RUN: time view.
  - 1 SET_H, 2 SET_M, 3 SET_S: time edit.
  - 4 VIEW_ALM: alarm k view.
  - 5 ALM_H, 6 ALM_M: alarm k edit.
- FSM transitions:
  - RUN: mode_pulse moves to VIEW_ALM with view_sel=1. adjust_pulse moves to SET_H.
  - VIEW_ALM: mode_pulse increments view_sel. From view_sel=NUM_ALARMS, mode_pulse returns to RUN with view_sel=0.
  - VIEW_ALM: adjust_pulse moves to ALM_H. up_pulse toggles alarm_en[view_sel-1].
  - Time edit: adjust_pulse steps SET_H to SET_M to SET_S to RUN.
  - Alarm edit: adjust_pulse steps ALM_H to ALM_M to VIEW_ALM.
  - mode_pulse is ignored in all edit states.
- Edit arithmetic:
  - up_pulse adds 1 to the field in edit, down_pulse subtracts 1.
  - Wrap is modulo the field (hours 24, min/sec 60), with no carry into other fields.
  - up_pulse and down_pulse in the same cycle: no change.
- Clock during edit:
  - In SET_H and SET_M the clock keeps running, and tick carries still apply.
  - If an edit and a tick carry hit the same field in the same cycle, the edit wins.
  - In SET_S the prescaler is held at 0 and time is frozen. Leaving SET_S restarts a full second.
- blink_mask: 110000 in SET_H/ALM_H, 001100 in SET_M/ALM_M, 000011 in SET_S, otherwise 000000.
- disp_bcd in alarm views and alarm edit: seconds digits read 0.
- Alarm match:
  - Fires on the tick that makes time HH:MM:00, for an enabled alarm with equal HH:MM.
  - Requires state not in SET_H/SET_M/SET_S.
  - Action: ring=1 next cycle, ring_src = lowest matching index, ring counter loaded with RING_SECS.
  - A match while already ringing reloads the counter and updates ring_src.
- Ring stop:
  - The counter decrements per sec_tick, and ring drops on the tick it reaches 0.
  - Any button pulse while ring=1 clears ring next cycle and is consumed: no FSM or edit effect.
  - A match and a button pulse in the same cycle: the match wins, ring stays 1 and the pulse is consumed.
- Reset mid-ring or mid-edit: immediate return to reset values.

Test Plan:
- Reset and tick, CLK_FREQ=10: assert rst for 3 cycles, release -> disp_bcd=0x000000, state=0, ring=0. sec_tick every 10th cycle; after 10 ticks S=10.
- Wrap: preload 23:59:59 via SET edits, run one tick -> disp_bcd=0x000000 one cycle after sec_tick.
- Hour edit: adjust_pulse -> state=1, blink_mask=110000. down_pulse at H=00 -> 23. 25 up_pulse -> 00 (wraps 23 to 00, then up to 00). Up+down same cycle -> unchanged.
- Seconds freeze: enter SET_S at S=07, wait 50 cycles -> S=07, no sec_tick. Exit -> first sec_tick 10 cycles later.
- Alarm match and acknowledge, NUM_ALARMS=2:
  - Alarms 0 and 1 both set to 00:01 and enabled, RUN from 00:00:58.
  - At 00:01:00 -> ring=1, ring_src=0.
  - up_pulse -> ring=0, state stays RUN, alarm_en unchanged.
- Ring timeout and reset: RING_SECS=3 -> ring clears on 3rd tick after start. Separately, assert rst mid-ring -> ring=0 immediately, alarm_en=0.
